power_seq: RTL and testbench
============================

Name: power_seq

Overview:
- Rail sequencer on the consuming end of the power-FSM `pwr_enable` request.
- On power-up it turns rails on in order, one at a time. It waits for each rail's power-good before the next, then releases system reset.
- On power-down it asserts reset first, then turns rails off in reverse order.
- All timing counts slow-clock enable (`ce`) ticks. It sits between the power FSM and the board regulator enables.

Parameters:
- NUM_RAILS, 3: number of sequenced rails; rail 0 comes up first.
- RAIL_DELAY, 4'd2: ce ticks between a rail's pg going high and the next rail_en.
- PG_TIMEOUT, 4'd8: ce ticks allowed for an enabled rail's pg to rise.
- RESET_DELAY, 4'd4: ce ticks from the last pg (all up) to sys_rst_n release.
- OFF_DELAY, 4'd2: ce ticks between successive rail disables on power-down.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  slow clock enable, one clk wide
- pwr_enable  in  1  power request from power FSM, level
- pg  in  NUM_RAILS  power-good per rail; synchronous to clk (synchronised upstream)
- rail_en  out  NUM_RAILS  regulator enables
- sys_rst_n  out  1  system reset, active low
- pwr_good  out  1  high only in ON
- pwr_fault  out  1  sticky fault flag

Behaviour:
- Reset values: state OFF, rail_en=0, sys_rst_n=0, pwr_good=0, pwr_fault=0, counter=0, rail index=0.
- Timing rules:
  - Counter decrements only on clk edges with ce=1.
  - State decisions on pg and pwr_enable are taken on every clk.
  - All outputs are registered, so outputs change one clk after the state decision.
- States and transitions:
  - OFF:
    - pwr_enable=1 → UP_EN with idx=0, rail_en[0]=1, counter=PG_TIMEOUT, pwr_fault cleared.
  - UP_EN:
    - pg[idx]=1 → UP_DLY with counter=RAIL_DELAY.
    - Counter reaches 0 with pg[idx]=0 → FAULT.
  - UP_DLY:
    - Counter=0 and idx<NUM_RAILS-1 → idx+1, set rail_en[idx+1], counter=PG_TIMEOUT, → UP_EN.
    - Counter=0 and idx=NUM_RAILS-1 → RST_HOLD with counter=RESET_DELAY.
  - RST_HOLD:
    - Counter=0 → ON, sys_rst_n=1, pwr_good=1.
  - ON:
    - pwr_enable=0 → DOWN_RST.
  - DOWN_RST (one clk):
    - sys_rst_n=0, pwr_good=0 → DOWN_DIS.
  - DOWN_DIS:
    - Clear the highest set rail_en bit, counter=OFF_DELAY.
    - After the counter expires, repeat with the next highest set bit.
    - When rail_en=0 and the counter has expired → OFF.
  - FAULT:
    - On entry: rail_en=0 at once (all rails), sys_rst_n=0, pwr_good=0, pwr_fault=1.
    - Stay until pwr_enable=0, then → OFF. pwr_fault stays set.
- pg loss:
  - Any rail with rail_en=1 whose pg was already seen high, now low, in UP_EN (rails below idx), UP_DLY, RST_HOLD or ON → FAULT next clk.
  - pg loss during DOWN_DIS is ignored.
- pwr_enable dropped mid power-up (UP_EN, UP_DLY, RST_HOLD) → DOWN_RST. Only rails already enabled are sequenced off, in reverse order.
- pwr_enable reasserted during DOWN_RST or DOWN_DIS → ignored. The down sequence completes to OFF; the next clk in OFF restarts power-up.
- Simultaneous pg loss and pwr_enable=0 → FAULT takes priority.
- pg for rails with rail_en=0 is don't-care.
- Async rst_n assertion mid-sequence → all outputs go to reset values immediately, with no orderly power-down.
- Counters are 4 bits wide, load the parameter value, and saturate at 0.
- A parameter value of 0 means the wait expires on the first clk after load.

Decomposition:
- Include file power_seq_defs.v: localparam state encodings (OFF, UP_EN, UP_DLY, RST_HOLD, ON, DOWN_RST, DOWN_DIS, FAULT) and the counter width.
- One sub-module, power_seq_timer: ce-gated 4-bit loadable down-counter with a `load` input and a `zero` output. It is shared by all wait states.

Test Plan:
- Power-up, ce every 4 clk, pg[i] rising 1 ce tick after rail_en[i]:
  - rail_en goes 001 → 011 → 111, each step 3 ticks apart (1 for pg plus RAIL_DELAY 2).
  - sys_rst_n rises 4 ticks after the last delay, then pwr_good=1.
- Power-down from ON, pwr_enable 1→0:
  - sys_rst_n=0 within 2 clk.
  - rail_en goes 111 → 011 → 001 → 000, 2 ticks apart, then OFF.
- pg[1] held low:
  - After 8 ce ticks in UP_EN, rail_en=000 and pwr_fault=1.
  - pwr_enable=0 → OFF with pwr_fault still 1.
  - Next pwr_enable=1 clears pwr_fault.
- In ON, pg[0] drops for one clk → FAULT: rail_en=000 in the same cycle as sys_rst_n=0.
- pwr_enable dropped while in UP_EN for rail 1 (rail_en=011) → rails go 011 → 001 → 000; rail 2 is never enabled.
- rst_n pulsed low while in ON → rail_en=000, sys_rst_n=0 asynchronously. After release the block stays in OFF until pwr_enable is sampled high, then restarts power-up.

Source files
------------

// File: rtl/power_seq_pkg.sv
// power_seq package: state enum and counter type.
package power_seq_pkg;
  `include "power_seq_defs.v"

  typedef enum logic [2:0] {
    S_OFF      = ST_OFF,
    S_UP_EN    = ST_UP_EN,
    S_UP_DLY   = ST_UP_DLY,
    S_RST_HOLD = ST_RST_HOLD,
    S_ON       = ST_ON,
    S_DOWN_RST = ST_DOWN_RST,
    S_DOWN_DIS = ST_DOWN_DIS,
    S_FAULT    = ST_FAULT
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/power_seq_defs.v
// power_seq shared encodings: FSM state codes and wait-counter width.
`ifndef POWER_SEQ_DEFS_V
`define POWER_SEQ_DEFS_V
localparam int CNT_W = 4;
localparam logic [2:0] ST_OFF      = 3'd0;
localparam logic [2:0] ST_UP_EN    = 3'd1;
localparam logic [2:0] ST_UP_DLY   = 3'd2;
localparam logic [2:0] ST_RST_HOLD = 3'd3;
localparam logic [2:0] ST_ON       = 3'd4;
localparam logic [2:0] ST_DOWN_RST = 3'd5;
localparam logic [2:0] ST_DOWN_DIS = 3'd6;
localparam logic [2:0] ST_FAULT    = 3'd7;
`endif

// File: rtl/power_seq_timer.sv
// ce-gated loadable down-counter shared by every wait state.
module power_seq_timer
  import power_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic load,
  input  cnt_t load_val,
  output logic zero
);

  cnt_t cnt_q, cnt_d;

  // load wins over a same-cycle tick; count parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (ce && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/power_seq.sv
// Rail sequencer: ordered rail bring-up with pg supervision,
// reset release, reverse-order shutdown and sticky fault.
module power_seq
  import power_seq_pkg::*;
#(
  parameter int   NUM_RAILS   = 3,
  parameter cnt_t RAIL_DELAY  = 4'd2,
  parameter cnt_t PG_TIMEOUT  = 4'd8,
  parameter cnt_t RESET_DELAY = 4'd4,
  parameter cnt_t OFF_DELAY   = 4'd2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 pwr_enable,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 sys_rst_n,
  output logic                 pwr_good,
  output logic                 pwr_fault
);

  localparam int IW = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_RAILS - 1);
  localparam logic [NUM_RAILS-1:0] ONE = NUM_RAILS'(1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_RAILS-1:0] en_q, en_d;
  logic                 srst_n_q, srst_n_d;
  logic                 good_q, good_d;
  logic                 fault_q, fault_d;
  logic                 load, zero, lost;
  logic                 to_fault, to_down;
  cnt_t                 load_val;

  power_seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    en_d     = en_q;
    srst_n_d = srst_n_q;
    good_d   = good_q;
    fault_d  = fault_q;
    load     = 1'b0;
    load_val = '0;
    lost     = 1'b0;
    to_fault = 1'b0;
    to_down  = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (pwr_enable) begin
          state_d  = S_UP_EN;
          idx_d    = '0;
          en_d     = ONE;
          fault_d  = 1'b0;
          load     = 1'b1;
          load_val = PG_TIMEOUT;
        end
      end
      S_UP_EN: begin
        // the rail being brought up has no pg history yet
        lost = |(en_q & ~(ONE << idx_q) & ~pg);
        if (lost || (zero && !pg[idx_q])) begin
          to_fault = 1'b1;
        end else if (!pwr_enable) begin
          to_down = 1'b1;
        end else if (pg[idx_q]) begin
          state_d  = S_UP_DLY;
          load     = 1'b1;
          load_val = RAIL_DELAY;
        end
      end
      S_UP_DLY: begin
        lost = |(en_q & ~pg);
        if (lost) begin
          to_fault = 1'b1;
        end else if (!pwr_enable) begin
          to_down = 1'b1;
        end else if (zero) begin
          load = 1'b1;
          if (idx_q == LAST) begin
            state_d  = S_RST_HOLD;
            load_val = RESET_DELAY;
          end else begin
            state_d  = S_UP_EN;
            idx_d    = idx_q + 1'b1;
            en_d     = en_q | (ONE << (idx_q + 1'b1));
            load_val = PG_TIMEOUT;
          end
        end
      end
      S_RST_HOLD: begin
        lost = |(en_q & ~pg);
        if (lost) begin
          to_fault = 1'b1;
        end else if (!pwr_enable) begin
          to_down = 1'b1;
        end else if (zero) begin
          state_d  = S_ON;
          srst_n_d = 1'b1;
          good_d   = 1'b1;
        end
      end
      S_ON: begin
        lost = |(en_q & ~pg);
        if (lost) begin
          to_fault = 1'b1;
        end else if (!pwr_enable) begin
          to_down = 1'b1;
        end
      end
      S_DOWN_RST: begin
        // enabled rails are always a low-order prefix
        state_d  = S_DOWN_DIS;
        en_d     = en_q >> 1;
        load     = 1'b1;
        load_val = OFF_DELAY;
      end
      S_DOWN_DIS: begin
        if (zero) begin
          if (en_q == '0) begin
            state_d = S_OFF;
          end else begin
            en_d     = en_q >> 1;
            load     = 1'b1;
            load_val = OFF_DELAY;
          end
        end
      end
      S_FAULT: begin
        if (!pwr_enable) begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase
    if (to_fault) begin
      state_d  = S_FAULT;
      en_d     = '0;
      srst_n_d = 1'b0;
      good_d   = 1'b0;
      fault_d  = 1'b1;
    end else if (to_down) begin
      state_d  = S_DOWN_RST;
      srst_n_d = 1'b0;
      good_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      idx_q    <= '0;
      en_q     <= '0;
      srst_n_q <= 1'b0;
      good_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      srst_n_q <= srst_n_d;
      good_q   <= good_d;
      fault_q  <= fault_d;
    end
  end

  assign rail_en   = en_q;
  assign sys_rst_n = srst_n_q;
  assign pwr_good  = good_q;
  assign pwr_fault = fault_q;

endmodule

// File: tb/tb_power_seq.sv
// power_seq bench: directed scenarios then random traffic,
// every cycle compared against a rail-count reference model.
module tb_power_seq;

  localparam int N       = 3;
  localparam int T_RAIL  = 2;
  localparam int T_PG    = 8;
  localparam int T_RST   = 4;
  localparam int T_OFF   = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0;
  logic         pwr_enable = 1'b0;
  logic [N-1:0] pg = '0;
  logic [N-1:0] rail_en;
  logic         sys_rst_n;
  logic         pwr_good;
  logic         pwr_fault;

  power_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .pwr_enable (pwr_enable),
    .pg         (pg),
    .rail_en    (rail_en),
    .sys_rst_n  (sys_rst_n),
    .pwr_good   (pwr_good),
    .pwr_fault  (pwr_fault)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // reference model: phase name, number of rails on, rails with pg proven
  string ph = "OFF";
  int    m_on = 0;
  int    m_proven = 0;
  int    m_wait = 0;
  bit    m_rst = 1'b0;
  bit    m_good = 1'b0;
  bit    m_fault = 1'b0;

  // board and bookkeeping
  logic [N-1:0] ready = '0;
  logic [N-1:0] stuck = '0;
  logic [N-1:0] noise = '0;
  logic [N-1:0] or_en = '0;
  logic [3:0]   last_obs = '0;
  bit           rand_mode = 1'b0;
  int           tcnt = 0;
  int           ce_ticks = 0;
  int           ev_tick[$];
  logic [3:0]   ev_val[$];

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_en();
    return N'((1 << m_on) - 1);
  endfunction

  task automatic m_reset();
    ph = "OFF";
    m_on = 0;
    m_proven = 0;
    m_wait = 0;
    m_rst = 1'b0;
    m_good = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic m_step(input bit pe, input bit c, input logic [N-1:0] p);
    bit expired, lost, flt, dn;
    int nw;
    expired = (m_wait == 0);
    nw = (c && m_wait > 0) ? m_wait - 1 : m_wait;
    lost = 1'b0;
    flt = 1'b0;
    dn = 1'b0;
    for (int i = 0; i < m_proven; i++) if (p[i] !== 1'b1) lost = 1'b1;
    if (ph == "OFF") begin
      if (pe) begin
        ph = "UP_EN"; m_on = 1; m_proven = 0; nw = T_PG; m_fault = 1'b0;
      end
    end else if (ph == "UP_EN") begin
      if (lost || (expired && !p[m_on-1])) flt = 1'b1;
      else if (!pe) dn = 1'b1;
      else if (p[m_on-1]) begin
        ph = "UP_DLY"; m_proven = m_on; nw = T_RAIL;
      end
    end else if (ph == "UP_DLY") begin
      if (lost) flt = 1'b1;
      else if (!pe) dn = 1'b1;
      else if (expired) begin
        if (m_on < N) begin
          m_on++; ph = "UP_EN"; nw = T_PG;
        end else begin
          ph = "RST_HOLD"; nw = T_RST;
        end
      end
    end else if (ph == "RST_HOLD") begin
      if (lost) flt = 1'b1;
      else if (!pe) dn = 1'b1;
      else if (expired) begin
        ph = "ON"; m_rst = 1'b1; m_good = 1'b1;
      end
    end else if (ph == "ON") begin
      if (lost) flt = 1'b1;
      else if (!pe) dn = 1'b1;
    end else if (ph == "DOWN_RST") begin
      ph = "DOWN_DIS"; m_on--; nw = T_OFF;
    end else if (ph == "DOWN_DIS") begin
      if (expired) begin
        if (m_on == 0) ph = "OFF";
        else begin
          m_on--; nw = T_OFF;
        end
      end
    end else if (ph == "FAULT") begin
      if (!pe) ph = "OFF";
    end
    if (flt) begin
      ph = "FAULT"; m_on = 0; m_proven = 0;
      m_rst = 1'b0; m_good = 1'b0; m_fault = 1'b1;
    end else if (dn) begin
      ph = "DOWN_RST"; m_proven = 0; m_rst = 1'b0; m_good = 1'b0;
    end
    m_wait = nw;
  endtask

  task automatic ev_clear();
    ev_tick.delete();
    ev_val.delete();
    last_obs = {sys_rst_n, rail_en};
  endtask

  // one clock: edge, model update, check, then drive next inputs
  task automatic cyc();
    logic [N-1:0] en_prev;
    int k;
    en_prev = rail_en;
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step(pwr_enable, ce, pg);
    if (ce) ce_ticks++;
    #1;
    chk("rail_en", 8'(rail_en), 8'(m_en()));
    chk("sys_rst_n", 8'(sys_rst_n), 8'(m_rst));
    chk("pwr_good", 8'(pwr_good), 8'(m_good));
    chk("pwr_fault", 8'(pwr_fault), 8'(m_fault));
    if ({sys_rst_n, rail_en} !== last_obs) begin
      last_obs = {sys_rst_n, rail_en};
      ev_tick.push_back(ce_ticks);
      ev_val.push_back(last_obs);
    end
    or_en |= rail_en;
    if (ce) ready |= en_prev;
    ready &= rail_en;
    @(negedge clk);
    tcnt++;
    if (rand_mode) begin
      ce = ($urandom_range(0, 3) == 0);
      noise = N'($urandom);
      pg = (ready & ~stuck) | (noise & ~rail_en);
      if ($urandom_range(0, 119) == 0) begin
        k = $urandom_range(0, N - 1);
        pg[k[1:0]] = 1'b0;
      end
    end else begin
      ce = (tcnt % 4 == 0);
      pg = ready & ~stuck;
    end
  endtask

  initial begin
    m_reset();
    repeat (3) cyc();
    chk("rst_rail_en", 8'(rail_en), 8'd0);
    chk("rst_sys_rst_n", 8'(sys_rst_n), 8'd0);
    chk("rst_pwr_good", 8'(pwr_good), 8'd0);
    chk("rst_pwr_fault", 8'(pwr_fault), 8'd0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // power-up with regular ce and well-behaved board
    ev_clear();
    pwr_enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (pwr_good === 1'b1) break;
    end
    chk("up_pwr_good", 8'(pwr_good), 8'd1);
    chk("up_nev", 8'(ev_val.size()), 8'd4);
    if (ev_val.size() == 4) begin
      chk("up_ev0", 8'(ev_val[0]), 8'h01);
      chk("up_ev1", 8'(ev_val[1]), 8'h03);
      chk("up_ev2", 8'(ev_val[2]), 8'h07);
      chk("up_ev3", 8'(ev_val[3]), 8'h0f);
      chk("up_gap1", 8'(ev_tick[1] - ev_tick[0]), 8'd3);
      chk("up_gap2", 8'(ev_tick[2] - ev_tick[1]), 8'd3);
      chk("up_rst_gap", 8'(ev_tick[3] - ev_tick[2]), 8'd7);
    end

    // orderly power-down
    ev_clear();
    pwr_enable = 1'b0;
    cyc();
    chk("dn_rst_fast", 8'(sys_rst_n), 8'd0);
    repeat (59) cyc();
    chk("dn_nev", 8'(ev_val.size()), 8'd4);
    if (ev_val.size() == 4) begin
      chk("dn_ev1", 8'(ev_val[1]), 8'h03);
      chk("dn_ev2", 8'(ev_val[2]), 8'h01);
      chk("dn_ev3", 8'(ev_val[3]), 8'h00);
      chk("dn_gap1", 8'(ev_tick[2] - ev_tick[1]), 8'd2);
      chk("dn_gap2", 8'(ev_tick[3] - ev_tick[2]), 8'd2);
    end

    // pg[1] never rises: timeout fault
    ev_clear();
    stuck = 3'b010;
    pwr_enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (pwr_fault === 1'b1) break;
    end
    chk("to_fault", 8'(pwr_fault), 8'd1);
    chk("to_rail_en", 8'(rail_en), 8'd0);
    chk("to_nev", 8'(ev_val.size()), 8'd3);
    if (ev_val.size() == 3) begin
      chk("to_ticks", 8'(ev_tick[2] - ev_tick[1]), 8'd8);
    end
    pwr_enable = 1'b0;
    repeat (5) cyc();
    chk("to_sticky", 8'(pwr_fault), 8'd1);
    stuck = '0;
    pwr_enable = 1'b1;
    cyc();
    chk("to_clear", 8'(pwr_fault), 8'd0);
    chk("to_restart", 8'(rail_en), 8'h01);
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (pwr_good === 1'b1) break;
    end
    chk("up2_pwr_good", 8'(pwr_good), 8'd1);

    // one-clk pg[0] dropout while on
    pg = pg & ~3'b001;
    cyc();
    chk("glitch_rail_en", 8'(rail_en), 8'd0);
    chk("glitch_sys_rst_n", 8'(sys_rst_n), 8'd0);
    chk("glitch_fault", 8'(pwr_fault), 8'd1);
    pwr_enable = 1'b0;
    repeat (4) cyc();

    // pwr_enable withdrawn while rail 1 is coming up
    or_en = '0;
    pwr_enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (rail_en === 3'b011) break;
    end
    chk("ab_reach", 8'(rail_en), 8'h03);
    ev_clear();
    pwr_enable = 1'b0;
    repeat (50) cyc();
    chk("ab_nev", 8'(ev_val.size()), 8'd2);
    if (ev_val.size() == 2) begin
      chk("ab_ev0", 8'(ev_val[0]), 8'h01);
      chk("ab_ev1", 8'(ev_val[1]), 8'h00);
      chk("ab_gap", 8'(ev_tick[1] - ev_tick[0]), 8'd2);
    end
    chk("ab_or_en", 8'(or_en), 8'h03);

    // asynchronous reset while on
    pwr_enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (pwr_good === 1'b1) break;
    end
    chk("up3_pwr_good", 8'(pwr_good), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rail_en", 8'(rail_en), 8'd0);
    chk("arst_sys_rst_n", 8'(sys_rst_n), 8'd0);
    chk("arst_pwr_good", 8'(pwr_good), 8'd0);
    m_reset();
    pwr_enable = 1'b0;
    @(negedge clk);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("arst_stay_off", 8'(rail_en), 8'd0);
    pwr_enable = 1'b1;
    cyc();
    chk("arst_restart", 8'(rail_en), 8'h01);
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (pwr_good === 1'b1) break;
    end
    chk("up4_pwr_good", 8'(pwr_good), 8'd1);

    // random traffic against the model
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (pwr_enable && $urandom_range(0, 149) == 0) pwr_enable = 1'b0;
      else if (!pwr_enable && $urandom_range(0, 19) == 0) pwr_enable = 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        stuck = (stuck == '0) ? N'(3'b001 << $urandom_range(0, N - 1)) : '0;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
